// File: rtl/lane_hit_judge.sv
// Per-lane hit judge: grades key presses against a falling block, tracks combo and score.
// Optional build macro LANE_HIT_JUDGE_COMBO_BONUS_EN: perfect hits at combo >= 10 score 3.
module lane_hit_judge #(
  parameter int HIT_CENTER = 600,
  parameter int PERFECT_W  = 8,
  parameter int GOOD_W     = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       stop_or_endgame,
  input  logic [9:0] block_h,
  input  logic       key,
  output logic       hit,
  output logic       miss,
  output logic [1:0] grade,
  output logic [6:0] combo,
  output logic [13:0] score
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;

  localparam logic [9:0]         NO_BLOCK  = 10'd720;
  localparam logic signed [10:0] CENTER_S  = 11'(HIT_CENTER);
  localparam logic signed [10:0] PERFECT_S = 11'(PERFECT_W);
  localparam logic signed [10:0] GOOD_S    = 11'(GOOD_W);
  localparam logic [1:0] G_NONE = 2'b00, G_GOOD = 2'b01, G_PERFECT = 2'b10, G_MISS = 2'b11;

  function automatic logic [13:0] sat_score(input logic [13:0] s, input logic [1:0] inc);
    logic [14:0] sum;
    sum = {1'b0, s} + {13'd0, inc};
    return (sum > 15'd9999) ? 14'd9999 : sum[13:0];
  endfunction

  function automatic logic [6:0] sat_combo(input logic [6:0] c);
    return (c >= 7'd99) ? 7'd99 : c + 7'd1;
  endfunction

  state_t            state, state_nxt;
  logic [9:0]        prev_h;
  logic              prev_key;
  logic              key_rise, respawn;
  logic signed [10:0] diff, mag;
  logic              in_perfect, in_good, late;
  logic              ev_hit, ev_miss, ev_perf;
  logic [1:0]        pts;

  assign key_rise = key & ~prev_key;
  assign respawn  = block_h < prev_h;

  // 11-bit signed distance from the judge line; cannot wrap for any 10-bit block_h
  assign diff       = $signed({1'b0, block_h}) - CENTER_S;
  assign mag        = (diff < 0) ? -diff : diff;
  assign in_perfect = mag <= PERFECT_S;
  assign in_good    = mag <= GOOD_S;
  assign late       = diff > GOOD_S;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               state <= IDLE;
    else if (restart)         state <= IDLE;
    else if (!stop_or_endgame) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (block_h < NO_BLOCK) state_nxt = ACTIVE;
      ACTIVE: begin
        if (respawn)                   state_nxt = ACTIVE;
        else if (block_h == NO_BLOCK)  state_nxt = IDLE;
        else if (key_rise && in_good)  state_nxt = DONE;
        else if (late)                 state_nxt = DONE;
      end
      DONE: begin
        if (respawn)                   state_nxt = ACTIVE;
        else if (block_h == NO_BLOCK)  state_nxt = IDLE;
      end
      default:                         state_nxt = IDLE;
    endcase
  end

  // Judgment events; respawn outranks a same-cycle key press
  always_comb begin
    ev_hit  = 1'b0;
    ev_miss = 1'b0;
    ev_perf = 1'b0;
    if (state == ACTIVE) begin
      if (respawn || block_h == NO_BLOCK) begin
        ev_miss = 1'b1;
      end else if (key_rise && in_good) begin
        ev_hit  = 1'b1;
        ev_perf = in_perfect;
      end else if (late) begin
        ev_miss = 1'b1;
      end
    end
    pts = ev_perf ? 2'd2 : 2'd1;
`ifdef LANE_HIT_JUDGE_COMBO_BONUS_EN
    if (ev_perf && combo >= 7'd10) pts = 2'd3;
`endif
  end

  // Registered outputs; stop freezes everything except that pulses drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_h   <= NO_BLOCK;
      prev_key <= 1'b0;
      hit      <= 1'b0;
      miss     <= 1'b0;
      grade    <= G_NONE;
      combo    <= 7'd0;
      score    <= 14'd0;
    end else if (restart) begin
      prev_h   <= NO_BLOCK;
      prev_key <= 1'b0;
      hit      <= 1'b0;
      miss     <= 1'b0;
      grade    <= G_NONE;
      combo    <= 7'd0;
      score    <= 14'd0;
    end else if (stop_or_endgame) begin
      hit  <= 1'b0;
      miss <= 1'b0;
    end else begin
      prev_h   <= block_h;
      prev_key <= key;
      hit      <= ev_hit;
      miss     <= ev_miss;
      if (ev_hit) begin
        grade <= ev_perf ? G_PERFECT : G_GOOD;
        combo <= sat_combo(combo);
        score <= sat_score(score, pts);
      end else if (ev_miss) begin
        grade <= G_MISS;
        combo <= 7'd0;
      end
    end
  end

endmodule

// File: tb/tb_lane_hit_judge.sv
// Directed table-driven bench for lane_hit_judge plus multi-cycle sequences.
module tb_lane_hit_judge;
  logic       clk = 1'b0;
  logic       rst_n, restart, stop_or_endgame, key;
  logic [9:0] block_h;
  logic       hit, miss;
  logic [1:0] grade;
  logic [6:0] combo;
  logic [13:0] score;

  int n_chk = 0, n_pass = 0;

  lane_hit_judge dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .stop_or_endgame(stop_or_endgame),
    .block_h(block_h), .key(key), .hit(hit), .miss(miss), .grade(grade),
    .combo(combo), .score(score)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int e_hit;
    int e_miss;
    int e_grade;
    int e_score;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int h, input logic k);
    block_h = 10'(h);
    key     = k;
    step();
  endtask

  task automatic do_restart();
    restart = 1'b1;
    block_h = 10'd720;
    key     = 1'b0;
    step();
    restart = 1'b0;
  endtask

  task automatic chk_out(input string name, input int eh, input int em, input int eg,
                         input int ec, input int es);
    chk({name, ".hit"}, int'(hit), eh);
    chk({name, ".miss"}, int'(miss), em);
    chk({name, ".grade"}, int'(grade), eg);
    chk({name, ".combo"}, int'(combo), ec);
    chk({name, ".score"}, int'(score), es);
  endtask

  vec_t tbl[10];
  int   exp_sc;

  initial begin
    tbl[0] = '{600, 1, 0, 2, 2};
    tbl[1] = '{592, 1, 0, 2, 2};
    tbl[2] = '{608, 1, 0, 2, 2};
    tbl[3] = '{591, 1, 0, 1, 1};
    tbl[4] = '{609, 1, 0, 1, 1};
    tbl[5] = '{576, 1, 0, 1, 1};
    tbl[6] = '{624, 1, 0, 1, 1};
    tbl[7] = '{575, 0, 0, 0, 0};
    tbl[8] = '{625, 0, 1, 3, 0};
    tbl[9] = '{120, 0, 0, 0, 0};

    rst_n = 1'b0; restart = 1'b0; stop_or_endgame = 1'b0; key = 1'b0; block_h = 10'd720;
    #3;
    chk_out("reset", 0, 0, 0, 0, 0);
    #9 rst_n = 1'b1;
    step();

    // Single-press window table: fresh block at 120, then key rises at tbl[i].h
    for (int i = 0; i < 10; i++) begin
      do_restart();
      apply(120, 1'b0);
      apply(tbl[i].h, 1'b1);
      chk_out($sformatf("win%0d", tbl[i].h), tbl[i].e_hit, tbl[i].e_miss, tbl[i].e_grade,
              tbl[i].e_hit, tbl[i].e_score);
      apply(tbl[i].h, 1'b0);
      chk("pulse_drop.hit", int'(hit), 0);
    end

    // Perfect hit on a ramp, single-cycle pulse
    do_restart();
    apply(120, 0); apply(300, 0); apply(500, 0); apply(590, 0);
    apply(603, 1);
    chk_out("ramp603", 1, 0, 2, 1, 2);
    apply(610, 1);
    chk_out("ramp603_next", 0, 0, 2, 1, 2);

    // Good hit, key held: no second judgment
    do_restart();
    apply(120, 0);
    apply(580, 1);
    chk_out("held580", 1, 0, 1, 1, 1);
    apply(590, 1); apply(600, 1);
    chk_out("held600", 0, 0, 1, 1, 1);

    // Late miss at 625
    do_restart();
    apply(120, 0); apply(500, 0); apply(600, 0); apply(620, 0);
    chk("pre625.miss", int'(miss), 0);
    apply(625, 0);
    chk_out("miss625", 0, 1, 3, 0, 0);
    apply(640, 0);
    chk("miss625_next.miss", int'(miss), 0);

    // Respawn outranks key press; FSM stays ACTIVE
    do_restart();
    apply(120, 0); apply(300, 0);
    apply(120, 1);
    chk_out("respawn", 0, 1, 3, 0, 0);
    apply(400, 0);
    apply(600, 1);
    chk_out("respawn_active", 1, 0, 2, 1, 2);

    // Block leaves unjudged: miss; leaving from DONE: no miss
    do_restart();
    apply(120, 0); apply(500, 0);
    apply(720, 0);
    chk_out("exit720", 0, 1, 3, 0, 0);
    apply(120, 0); apply(600, 1); apply(650, 0);
    apply(720, 0);
    chk_out("done720", 0, 0, 2, 1, 2);

    // Restart mid-block discards the pending judgment
    do_restart();
    apply(120, 0); apply(620, 0);
    do_restart();
    chk_out("restart_mid", 0, 0, 0, 0, 0);

    // Stop freezes judging and the key edge register
    do_restart();
    apply(120, 0); apply(630, 0);
    apply(120, 0); apply(600, 0);
    stop_or_endgame = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apply(600, (i % 2) == 0);
      chk_out($sformatf("stop%0d", i), 0, 0, 3, 0, 0);
    end
    stop_or_endgame = 1'b0;
    apply(600, 1);
    chk_out("stop_release", 1, 0, 2, 1, 2);

    // Twelve perfect hits, bonus depends on build
    do_restart();
    for (int i = 0; i < 12; i++) begin
      apply(120, 0); apply(600, 1); apply(600, 0);
    end
`ifdef LANE_HIT_JUDGE_COMBO_BONUS_EN
    exp_sc = 26;
`else
    exp_sc = 24;
`endif
    chk_out("twelve", 0, 0, 2, 12, exp_sc);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0, 0);
    #3 rst_n = 1'b1;
    step();

    // Saturation of score and combo
    do_restart();
    for (int i = 0; i < 5000; i++) begin
      apply(120, 0); apply(600, 1); apply(600, 0);
    end
    chk("sat.score", int'(score), 9999);
    chk("sat.combo", int'(combo), 99);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
